// File: rtl/capture_buffer_if.sv
// rtl/capture_buffer_if.sv - capture/readout signal bundle for capture_buffer
interface capture_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  arm;
  logic [ADDR_WIDTH-1:0] pretrig;
  logic [DATA_WIDTH-1:0] din;
  logic                  din_vld;
  logic                  trig;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_vld;
  logic                  rd_last;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] trig_addr;

  modport master (
    output arm, pretrig, din, din_vld, trig, rd_en,
    input  rd_data, rd_vld, rd_last, busy, done, trig_addr
  );

  modport slave (
    input  arm, pretrig, din, din_vld, trig, rd_en,
    output rd_data, rd_vld, rd_last, busy, done, trig_addr
  );
endinterface

// File: rtl/capture_buffer.sv
// rtl/capture_buffer.sv - pre/post-trigger circular capture buffer with oldest-first readout
module capture_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input logic              clka,
  input logic              rsta_n,
  capture_buffer_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ALL_ONES = '1;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_pre_n;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_vld;
  logic                  r_rd_last;

  logic                  w_capturing;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_post_cnt;
  logic [ADDR_WIDTH-1:0] w_trig_base;
  logic [ADDR_WIDTH-1:0] w_rd_start;
  logic [DATA_WIDTH-1:0] w_mem_q;

  assign w_capturing = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_wr_en     = w_capturing && bus.din_vld && !bus.arm;
  assign w_rd_en     = (r_state == S_DONE) && bus.rd_en && !bus.arm;
  // Capture and readout never overlap, so one address port serves both.
  assign w_addr      = (r_state == S_DONE) ? r_rd_ptr : r_wr_ptr;
  assign w_mem_q     = r_mem[w_addr];
  // Samples still owed after the trigger sample: DEPTH-1-pre_n.
  assign w_post_cnt  = ~r_pre_n;
  assign w_trig_base = (r_state == S_WAIT) ? r_wr_ptr : r_trig_addr;
  assign w_rd_start  = w_trig_base - r_pre_n;

  assign bus.rd_data   = r_rd_data;
  assign bus.rd_vld    = r_rd_vld;
  assign bus.rd_last   = r_rd_last;
  assign bus.busy      = w_capturing;
  assign bus.done      = (r_state == S_DONE);
  assign bus.trig_addr = r_trig_addr;

  always_ff @(posedge clka) begin
    if (w_wr_en) begin
      r_mem[w_addr] <= bus.din;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_rd_vld  <= w_rd_en;
      r_rd_last <= w_rd_en && (r_cnt == ALL_ONES);
      if (w_rd_en) begin
        r_rd_data <= w_mem_q;
      end
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_pre_n     <= '0;
      r_trig_addr <= '0;
    end else if (bus.arm) begin
      r_pre_n  <= bus.pretrig;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_state  <= (bus.pretrig != '0) ? S_PRE : S_WAIT;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ONE;
      end
      case (r_state)
        S_PRE: begin
          if (bus.din_vld) begin
            if (r_cnt == r_pre_n - ONE) begin
              r_state <= S_WAIT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
        end
        S_WAIT: begin
          if (bus.din_vld && bus.trig) begin
            r_trig_addr <= r_wr_ptr;
            if (w_post_cnt == '0) begin
              r_state  <= S_DONE;
              r_rd_ptr <= w_rd_start;
              r_cnt    <= '0;
            end else begin
              r_state <= S_POST;
              r_cnt   <= w_post_cnt;
            end
          end
        end
        S_POST: begin
          if (bus.din_vld) begin
            if (r_cnt == ONE) begin
              r_state  <= S_DONE;
              r_rd_ptr <= w_rd_start;
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt - ONE;
            end
          end
        end
        S_DONE: begin
          // r_cnt doubles as the read counter; all-ones marks the final read.
          if (bus.rd_en) begin
            r_rd_ptr <= r_rd_ptr + ONE;
            r_cnt    <= r_cnt + ONE;
            if (r_cnt == ALL_ONES) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_capture_buffer.sv
// tb/tb_capture_buffer.sv - self-checking bench for capture_buffer (DEPTH 16, 8-bit ramp)
module tb_capture_buffer;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  capture_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) io ();
  capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clka   (clk),
    .rsta_n (rst_n),
    .bus    (io.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] ramp = 8'h00;

  // Reference model: counts of accepted samples since arm, not a state machine.
  bit         m_armed;
  int         m_pre, m_nacc, m_tidx, m_reads;
  logic [7:0] m_hist[$];
  logic [7:0] m_rd_data;
  logic       m_rd_vld, m_rd_last;
  logic [3:0] m_trig_addr;
  logic [7:0] obs_first, obs_last;
  int         obs_cnt;

  function automatic bit m_capturing();
    return m_armed && (m_tidx < 0 || (m_nacc - m_tidx) < DEPTH - m_pre);
  endfunction

  function automatic bit m_done();
    return m_armed && m_tidx >= 0 && (m_nacc - m_tidx) == DEPTH - m_pre;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_pre = 0; m_nacc = 0; m_tidx = -1; m_reads = 0;
    m_hist.delete();
    m_rd_data = '0; m_rd_vld = 1'b0; m_rd_last = 1'b0; m_trig_addr = '0;
  endtask

  task automatic model_cycle(input logic a, input logic [3:0] p, input logic [7:0] d,
                             input logic v, input logic t, input logic r);
    m_rd_vld = 1'b0;
    m_rd_last = 1'b0;
    if (a) begin
      m_armed = 1; m_pre = int'(p); m_nacc = 0; m_tidx = -1; m_reads = 0;
      m_hist.delete();
    end else if (m_capturing()) begin
      if (v) begin
        m_hist.push_back(d);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
        if (m_tidx < 0 && m_nacc >= m_pre && t) begin
          m_tidx = m_nacc;
          m_trig_addr = 4'(m_nacc % DEPTH);
        end
        m_nacc++;
      end
    end else if (m_done() && r) begin
      m_rd_vld  = 1'b1;
      m_rd_data = m_hist[m_reads];
      m_rd_last = (m_reads == DEPTH - 1);
      m_reads++;
      if (m_reads == DEPTH) m_armed = 0;
    end
  endtask

  task automatic check_outputs();
    chk("busy",      32'(io.busy),      32'(m_capturing()));
    chk("done",      32'(io.done),      32'(m_done()));
    chk("rd_vld",    32'(io.rd_vld),    32'(m_rd_vld));
    chk("rd_last",   32'(io.rd_last),   32'(m_rd_last));
    chk("rd_data",   32'(io.rd_data),   32'(m_rd_data));
    chk("trig_addr", 32'(io.trig_addr), 32'(m_trig_addr));
    if (io.rd_vld) begin
      if (obs_cnt == 0) obs_first = io.rd_data;
      obs_last = io.rd_data;
      obs_cnt++;
    end
  endtask

  task automatic step(input logic a, input logic [3:0] p, input logic v,
                      input logic t, input logic r);
    io.arm = a; io.pretrig = p; io.din = ramp; io.din_vld = v; io.trig = t; io.rd_en = r;
    model_cycle(a, p, ramp, v, t, r);
    if (a) obs_cnt = 0;
    @(posedge clk);
    #1;
    ramp++;
    check_outputs();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy",      32'(io.busy),      32'd0);
    chk("rst_done",      32'(io.done),      32'd0);
    chk("rst_rd_vld",    32'(io.rd_vld),    32'd0);
    chk("rst_rd_last",   32'(io.rd_last),   32'd0);
    chk("rst_rd_data",   32'(io.rd_data),   32'd0);
    chk("rst_trig_addr", 32'(io.trig_addr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ramp(input logic [7:0] val);
    int guard = 0;
    while (ramp != val && guard < 300) begin
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
  endtask

  // Trig is high when ramp equals at or lies in [lo,hi]; din_vld pulses every gap+1 cycles after the trigger.
  task automatic run_capture(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] at,
                             input int max_reads, input int gap);
    int guard = 0;
    int k = 0;
    logic v, t;
    while (m_armed && guard < 600 && !(max_reads >= 0 && m_reads >= max_reads)) begin
      if (m_tidx >= 0) k++;
      v = (m_tidx < 0) || (k % (gap + 1) == 0);
      t = (ramp == at) || (ramp >= lo && ramp <= hi);
      step(1'b0, 4'd0, v, t, 1'b1);
      guard++;
    end
    n_tests++;
    assert (guard < 600) else begin
      n_fail++;
      $error("FAIL timeout: observed %0d cycles expected below 600", guard);
    end
  endtask

  task automatic check_record(input string tag, input logic [7:0] first, input logic [7:0] last);
    chk({tag, "_first"}, 32'(obs_first), 32'(first));
    chk({tag, "_last"},  32'(obs_last),  32'(last));
    chk({tag, "_count"}, 32'(obs_cnt),   32'(DEPTH));
    chk({tag, "_idle"},  32'(io.busy | io.done), 32'd0);
  endtask

  initial begin
    io.arm = 0; io.pretrig = '0; io.din = '0; io.din_vld = 0; io.trig = 0; io.rd_en = 0;
    obs_cnt = 0; obs_first = '0; obs_last = '0;
    model_reset();
    #2;
    apply_reset();

    // pretrig=4, trigger on 0x20
    wait_ramp(8'h0F);
    step(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    chk("s1_busy_after_arm", 32'(io.busy), 32'd1);
    run_capture(8'h01, 8'h00, 8'h20, -1, 0);
    chk("s1_trig_addr", 32'(io.trig_addr), 32'h0);
    check_record("s1", 8'h1C, 8'h2B);

    // pretrig=0, trigger on the very first sample
    wait_ramp(8'hFF);
    step(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    run_capture(8'h01, 8'h00, 8'h00, -1, 0);
    check_record("s2", 8'h00, 8'h0F);

    // pretrig=8, trig held during pre-trigger, dropped on 0x08, taken at 0x09
    wait_ramp(8'hFF);
    step(1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
    run_capture(8'h00, 8'h07, 8'h09, -1, 0);
    check_record("s3", 8'h01, 8'h10);

    // trig without din_vld in WAIT, then 3-cycle gaps in POST
    wait_ramp(8'h40);
    step(1'b1, 4'd2, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    chk("s4_still_busy", 32'(io.busy), 32'd1);
    chk("s4_not_done",   32'(io.done), 32'd0);
    run_capture(8'h01, 8'h00, 8'h46, -1, 3);
    chk("s4_count", 32'(obs_cnt), 32'(DEPTH));

    // reset in POST, then a clean pretrig=4 capture
    wait_ramp(8'h0F);
    step(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    while (ramp != 8'h24) step(1'b0, 4'd0, 1'b1, ramp == 8'h20, 1'b1);
    chk("s5_in_post", 32'(io.busy), 32'd1);
    apply_reset();
    wait_ramp(8'h0F);
    step(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    run_capture(8'h01, 8'h00, 8'h20, -1, 0);
    check_record("s5", 8'h1C, 8'h2B);

    // re-arm after 5 reads, arm coincident with rd_en
    wait_ramp(8'h0F);
    step(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    run_capture(8'h01, 8'h00, 8'h20, 5, 0);
    chk("s6_partial_reads", 32'(obs_cnt), 32'd5);
    wait_ramp(8'h0F);
    step(1'b1, 4'd4, 1'b1, 1'b1, 1'b1);
    chk("s6_rd_vld_low", 32'(io.rd_vld), 32'd0);
    chk("s6_busy",       32'(io.busy),   32'd1);
    run_capture(8'h01, 8'h00, 8'h20, -1, 0);
    check_record("s6", 8'h1C, 8'h2B);

    // randomized pretrig, din_vld, trig and rd_en
    for (int n = 0; n < 6; n++) begin
      int guard;
      step(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
      guard = 0;
      while (m_armed && guard < 2000) begin
        step(1'b0, 4'd0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 2) != 0));
        guard++;
      end
      n_tests++;
      assert (guard < 2000) else begin
        n_fail++;
        $error("FAIL rand_timeout: observed %0d cycles expected below 2000", guard);
      end
      chk("rand_count", 32'(obs_cnt), 32'(DEPTH));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
